// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshake bundle and FIFO write port shared by the arbiter and its environment.
// master = arbiter side; slave = requesters plus FIFO.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port scheduler with burst lock and MAX_BURST cap; zero-latency combinational datapath.
// A raised fifo_full blocks every write and freezes arbitration state, counting the stall.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       wclk,
    input  logic                       wrst,
    fifo_write_arbiter_if.master       bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       write_count,
    output logic [CNT_WIDTH-1:0]       stall_count
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]  owner, owner_nxt;
    logic [BW-1:0]  beat_cnt, beat_cnt_nxt;
    logic [BW-1:0]  beat_inc;

    logic           cand_vld;
    logic [PW-1:0]  cand;
    logic [PW-1:0]  sel;
    logic           sel_vld;
    logic           write;
    logic           stall;
    int             idx;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!cand_vld && bus.req_valid[PW'(idx)]) begin
                cand_vld = 1'b1;
                cand     = PW'(idx);
            end
        end
    end

    assign sel     = (state == BURST) ? owner : cand;
    assign sel_vld = (state == BURST) ? bus.req_valid[owner] : cand_vld;
    assign write   = sel_vld && !bus.fifo_full && !wrst;
    assign stall   = sel_vld && bus.fifo_full && !wrst;

    // In IDLE a write is always the first beat, so one compare covers both the
    // MAX_BURST==1 case and the cap inside a burst.
    assign beat_inc = (state == IDLE) ? BW'(1) : beat_cnt + 1'b1;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            beat_cnt    <= '0;
            write_count <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (write)
                write_count <= write_count + 1'b1;
            if (stall)
                stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        if (write) begin
            if (bus.req_last[sel] || (beat_inc == BW'(MAX_BURST))) begin
                state_nxt    = IDLE;
                rr_ptr_nxt   = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                beat_cnt_nxt = '0;
            end else begin
                state_nxt    = BURST;
                owner_nxt    = sel;
                beat_cnt_nxt = beat_inc;
            end
        end
    end

    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_w_en    = write;
        bus.fifo_data_in = '0;
        grant_id         = '0;
        busy             = (state == BURST);
        if (write) begin
            bus.req_ready[sel] = 1'b1;
            bus.fifo_data_in   = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            grant_id           = sel;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench: vector table for reset/round-robin/full, hand sequences for bursts and reset.
module tb_fifo_write_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int CW = 16;

    logic          wclk = 1'b0;
    logic          wrst;
    logic [1:0]    grant_id;
    logic          busy;
    logic [CW-1:0] write_count;
    logic [CW-1:0] stall_count;

    always #5 wclk = ~wclk;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .write_count (write_count),
        .stall_count (stall_count)
    );

    typedef struct {
        logic          rst;
        logic [3:0]    valid;
        logic [3:0]    last;
        logic          full;
        logic [3:0]    ready;
        logic          wen;
        logic [1:0]    gid;
        logic          bsy;
        logic [CW-1:0] wc;
        logic [CW-1:0] sc;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [31:0] dat);
        @(posedge wclk);
        #1;
        wrst          = r;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.fifo_full = f;
        bus.req_data  = dat;
        @(negedge wclk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] r, input logic w,
                              input logic [1:0] g, input logic [7:0] d, input logic b);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(r));
        chk({tag, ".w_en"},  32'(bus.fifo_w_en), 32'(w));
        chk({tag, ".gid"},   32'(grant_id), 32'(g));
        chk({tag, ".data"},  32'(bus.fifo_data_in), 32'(d));
        chk({tag, ".busy"},  32'(busy), 32'(b));
    endtask

    initial begin
        logic [7:0] exp_d;

        wrst          = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.fifo_full = 1'b0;
        bus.req_data  = '0;
        @(posedge wclk);

        // reset with all requesters valid
        tbl.push_back('{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0});
        // round-robin singles 0,1,2,3,0,1,2,3
        for (int g = 0; g < 8; g++)
            tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b0, 4'(1 << (g % 4)), 1'b1, 2'(g % 4), 1'b0,
                            16'(g), 16'd0});
        // full for 5 cycles with req2 valid, then released
        for (int s = 0; s < 5; s++)
            tbl.push_back('{1'b0, 4'h4, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 16'd8, 16'(s)});
        tbl.push_back('{1'b0, 4'h4, 4'hF, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 16'd8,  16'd5});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 16'd9,  16'd5});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 16'd10, 16'd5});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].full,
                  {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)});
            exp_d = tbl[i].wen ? 8'(8'h10 * tbl[i].gid + i) : 8'h00;
            expect_out($sformatf("vec%0d", i), tbl[i].ready, tbl[i].wen, tbl[i].gid, exp_d, tbl[i].bsy);
            chk($sformatf("vec%0d.write_count", i), 32'(write_count), 32'(tbl[i].wc));
            chk($sformatf("vec%0d.stall_count", i), 32'(stall_count), 32'(tbl[i].sc));
        end

        // rr_ptr is 1 here; a single from req3 moves it to 0
        drive(1'b0, 4'b1000, 4'b1000, 1'b0, 32'h3F00_0000);
        expect_out("lock.setup", 4'h8, 1'b1, 2'd3, 8'h3F, 1'b0);

        // burst lock: req0 3 words with a 2-cycle valid gap, req1 waiting
        drive(1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0000_B1A1);
        expect_out("lock.w1", 4'h1, 1'b1, 2'd0, 8'hA1, 1'b0);
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_B100);
        expect_out("lock.bub1", 4'h0, 1'b0, 2'd0, 8'h00, 1'b1);
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_B100);
        expect_out("lock.bub2", 4'h0, 1'b0, 2'd0, 8'h00, 1'b1);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0000_B1A2);
        expect_out("lock.w2", 4'h1, 1'b1, 2'd0, 8'hA2, 1'b1);
        drive(1'b0, 4'b0011, 4'b0001, 1'b0, 32'h0000_B1A3);
        expect_out("lock.w3", 4'h1, 1'b1, 2'd0, 8'hA3, 1'b1);
        drive(1'b0, 4'b0011, 4'b0011, 1'b0, 32'h0000_B1A4);
        expect_out("lock.req1", 4'h2, 1'b1, 2'd1, 8'hB1, 1'b0);

        // burst cap: rr_ptr=2 so req0 wins; 8 beats without last, one full stall in the middle
        for (int n = 1; n <= 8; n++) begin
            drive(1'b0, 4'b0011, 4'b0000, 1'b0, {16'h0000, 8'hB0, 8'(8'hC0 + n)});
            expect_out($sformatf("cap.w%0d", n), 4'h1, 1'b1, 2'd0, 8'(8'hC0 + n), n > 1);
            if (n == 4) begin
                drive(1'b0, 4'b0011, 4'b0000, 1'b1, 32'h0000_B0EE);
                expect_out("cap.full", 4'h0, 1'b0, 2'd0, 8'h00, 1'b1);
            end
        end
        drive(1'b0, 4'b0011, 4'b0010, 1'b0, 32'h0000_B9CF);
        expect_out("cap.req1", 4'h2, 1'b1, 2'd1, 8'hB9, 1'b0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0000_B9CA);
        expect_out("cap.resume", 4'h1, 1'b1, 2'd0, 8'hCA, 1'b0);
        drive(1'b0, 4'b0001, 4'b0001, 1'b0, 32'h0000_00CB);
        expect_out("cap.end", 4'h1, 1'b1, 2'd0, 8'hCB, 1'b1);

        // reset mid-burst: req1 two beats, then reset, then req0 and req1 compete
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_D100);
        expect_out("rst.b1", 4'h2, 1'b1, 2'd1, 8'hD1, 1'b0);
        drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_D200);
        expect_out("rst.b2", 4'h2, 1'b1, 2'd1, 8'hD2, 1'b1);
        drive(1'b1, 4'b0011, 4'b0000, 1'b0, 32'h0000_D3E3);
        chk("rst.during.ready", 32'(bus.req_ready), 32'h0);
        chk("rst.during.w_en",  32'(bus.fifo_w_en), 32'h0);
        drive(1'b0, 4'b0011, 4'b0011, 1'b0, 32'h0000_E1E0);
        expect_out("rst.after", 4'h1, 1'b1, 2'd0, 8'hE0, 1'b0);
        chk("rst.after.write_count", 32'(write_count), 32'd0);
        chk("rst.after.stall_count", 32'(stall_count), 32'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
        expect_out("idle", 4'h0, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("idle.write_count", 32'(write_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
